vga_term_ctrl: RTL and testbench
================================

// Module: vga_term_ctrl
// PURPOSE
// Terminal-style write sequencer for the VGA character memory write port. Accepts a stream of
// ASCII bytes with colour attributes over valid/ready, tracks a cursor, handles CR/LF/BS/FF,
// auto-wraps, and scrolls by rotating a top-row base plus a hardware line clear. Sits between
// the CPU/UART text source and the cmem write port; the VGA scanner adds scroll_base to its row.
// PARAMETERS
// ROWS   30  text rows; physical row addresses 0..ROWS-1
// COLS   70  text columns; column addresses 0..COLS-1
// PORTS
// clk          in   1  system clock
// rst_n        in   1  reset, asynchronous, active-low
// in_valid     in   1  in_char/in_fg/in_bg valid
// in_ready     out  1  controller can accept (high only in IDLE)
// in_char      in   8  ASCII byte
// in_fg        in   3  foreground colour for this byte
// in_bg        in   3  background colour for this byte
// we           out  1  cmem write enable
// wr_addr      out  5  cmem physical write row
// wc_addr      out  7  cmem write column
// w_ascii      out  8  cmem write data: ASCII
// w_fg_color   out  3  cmem write data: foreground
// w_bg_color   out  3  cmem write data: background
// scroll_base  out  5  physical row shown at screen top
// cursor_row   out  5  logical cursor row (0 = top of screen)
// cursor_col   out  7  cursor column
// BEHAVIOUR
// - Reset: state IDLE, in_ready=1, we=0, all addr/data outputs 0, scroll_base=0, cursor 0,0.
// - Handshake: byte accepted on rising clk when in_valid & in_ready. in_ready = (state==IDLE).
// - All cmem outputs registered: a write caused by an accept appears with we=1 the next cycle.
// - Physical row = (scroll_base + cursor_row) mod ROWS, computed without overflow in 6 bits.
// - 0x20..0x7E: write {char,fg,bg} at (phys row, cursor_col); then advance cursor.
//   Advance: col<COLS-1 -> col+1; else col=0 and do LF.
// - 0x0A LF: row<ROWS-1 -> row+1 (col unchanged); else SCROLL.
// - 0x0D CR: col=0, no write.  0x08 BS: col>0 -> col-1, no erase; col=0 -> no change.
// - 0x0C FF: enter CLEAR_ALL.  Any other byte: accepted, no write, no cursor change.
// - SCROLL: scroll_base = (base==ROWS-1)?0:base+1; row stays ROWS-1; enter CLEAR_LINE with
//   target = old base (the new bottom physical row) and clear attrs = accepted byte's fg/bg.
// - CLEAR_LINE: COLS cycles, one write/cycle: ascii 0x20, cols 0..COLS-1 ascending; then IDLE.
// - CLEAR_ALL: ROWS*COLS cycles, rows 0..ROWS-1 outer, cols inner, ascii 0x20, attrs from FF
//   byte; on entry scroll_base=0 and cursor=0,0 immediately; then IDLE.
// - Printable at (ROWS-1,COLS-1): char write cycle, then CLEAR_LINE writes follow back-to-back
//   (no idle cycle between); in_ready low from the cycle after accept until clear done.
// - Counters wrap exactly at COLS-1/ROWS-1; addresses never reach COLS or ROWS.
// - in_valid while busy: held off by in_ready=0; byte must be held stable by source.
// - Reset asserted mid-clear: abort immediately to reset values; no further writes.
// - Non-write cycles: we=0; data outputs hold last value.
// TESTING
// - Reset, send 'A'(0x41) fg=7 bg=1 -> next cycle we=1, row 0 col 0 data 0x41/7/1; cursor 0,1.
// - 70 printables on row 0 -> last write col 69; cursor becomes (1,0); no scroll, base 0.
// - Cursor (29,5), send LF -> base=1, cursor (29,5), 70 writes of 0x20 to phys row 0
//   cols 0..69, in_ready low exactly 70 cycles after accept cycle, then high.
// - Base=29, cursor (29,69), send 'Z' -> write phys row 28 col 69, base wraps to 0, clear row 29.
// - Send FF with bg=4 -> 2100 writes of 0x20/bg 4 covering all cells once; base 0, cursor 0,0.
// - CR, BS at col 0, byte 0x07 -> no writes; cursor col 0; assert rst_n low mid CLEAR_ALL ->
//   we drops same cycle, in_ready=1 after release.

Source files
------------

// File: rtl/vga_term_ctrl.sv
// vga_term_ctrl: terminal-style write sequencer for the VGA character memory.
// Takes ASCII bytes with colour attributes over valid/ready, keeps a cursor,
// interprets CR/LF/BS/FF, auto-wraps, and scrolls by rotating the top-row
// base and clearing the newly exposed physical row in hardware.
module vga_term_ctrl #(
    parameter int unsigned ROWS = 30,
    parameter int unsigned COLS = 70
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    input  logic [2:0] in_fg,
    input  logic [2:0] in_bg,
    output logic       we,
    output logic [4:0] wr_addr,
    output logic [6:0] wc_addr,
    output logic [7:0] w_ascii,
    output logic [2:0] w_fg_color,
    output logic [2:0] w_bg_color,
    output logic [4:0] scroll_base,
    output logic [4:0] cursor_row,
    output logic [6:0] cursor_col
);

    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [5:0] ROWS_W   = 6'(ROWS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR_LINE,
        S_CLEAR_ALL
    } state_t;

    state_t     state;
    logic [4:0] clr_row;
    logic [6:0] clr_col;
    logic [2:0] clr_fg;
    logic [2:0] clr_bg;

    logic       is_print;
    logic       do_lf;
    logic [5:0] row_sum;
    logic [4:0] phys_row;
    logic [4:0] next_base;

    assign in_ready = (state == S_IDLE);

    // Decode the incoming byte and map the logical cursor row onto a physical row
    always_comb begin
        is_print  = (in_char >= 8'h20) && (in_char <= 8'h7E);
        // A printable in the last column wraps, which behaves exactly like LF
        do_lf     = (is_print && (cursor_col == COL_LAST)) || (in_char == 8'h0A);
        row_sum   = {1'b0, scroll_base} + {1'b0, cursor_row};
        phys_row  = (row_sum >= ROWS_W) ? 5'(row_sum - ROWS_W) : row_sum[4:0];
        next_base = (scroll_base == ROW_LAST) ? '0 : scroll_base + 5'd1;
    end

    // Sequencer: accepts bytes in IDLE, runs line/screen clears, drives registered cmem writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            we          <= 1'b0;
            wr_addr     <= '0;
            wc_addr     <= '0;
            w_ascii     <= '0;
            w_fg_color  <= '0;
            w_bg_color  <= '0;
            scroll_base <= '0;
            cursor_row  <= '0;
            cursor_col  <= '0;
            clr_row     <= '0;
            clr_col     <= '0;
            clr_fg      <= '0;
            clr_bg      <= '0;
        end else begin
            we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_print) begin
                            we         <= 1'b1;
                            wr_addr    <= phys_row;
                            wc_addr    <= cursor_col;
                            w_ascii    <= in_char;
                            w_fg_color <= in_fg;
                            w_bg_color <= in_bg;
                            cursor_col <= (cursor_col == COL_LAST) ? '0 : cursor_col + 7'd1;
                        end else if (in_char == 8'h0D) begin
                            cursor_col <= '0;
                        end else if (in_char == 8'h08) begin
                            if (cursor_col != '0)
                                cursor_col <= cursor_col - 7'd1;
                        end

                        if (do_lf) begin
                            if (cursor_row != ROW_LAST) begin
                                cursor_row <= cursor_row + 5'd1;
                            end else begin
                                // Old base becomes the new bottom row; clear it
                                scroll_base <= next_base;
                                clr_row     <= scroll_base;
                                clr_col     <= '0;
                                clr_fg      <= in_fg;
                                clr_bg      <= in_bg;
                                state       <= S_CLEAR_LINE;
                            end
                        end

                        if (in_char == 8'h0C) begin
                            scroll_base <= '0;
                            cursor_row  <= '0;
                            cursor_col  <= '0;
                            clr_row     <= '0;
                            clr_col     <= '0;
                            clr_fg      <= in_fg;
                            clr_bg      <= in_bg;
                            state       <= S_CLEAR_ALL;
                        end
                    end
                end

                S_CLEAR_LINE: begin
                    we         <= 1'b1;
                    wr_addr    <= clr_row;
                    wc_addr    <= clr_col;
                    w_ascii    <= 8'h20;
                    w_fg_color <= clr_fg;
                    w_bg_color <= clr_bg;
                    if (clr_col == COL_LAST) begin
                        clr_col <= '0;
                        state   <= S_IDLE;
                    end else begin
                        clr_col <= clr_col + 7'd1;
                    end
                end

                S_CLEAR_ALL: begin
                    we         <= 1'b1;
                    wr_addr    <= clr_row;
                    wc_addr    <= clr_col;
                    w_ascii    <= 8'h20;
                    w_fg_color <= clr_fg;
                    w_bg_color <= clr_bg;
                    if (clr_col == COL_LAST) begin
                        clr_col <= '0;
                        if (clr_row == ROW_LAST) begin
                            clr_row <= '0;
                            state   <= S_IDLE;
                        end else begin
                            clr_row <= clr_row + 5'd1;
                        end
                    end else begin
                        clr_col <= clr_col + 7'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_term_ctrl.sv
// tb_vga_term_ctrl: scoreboard bench. The stimulus side runs a terminal model
// and queues every expected cmem write; a monitor pops and compares each write
// the DUT presents. Cursor, scroll base, write latency and busy length are
// checked after each accepted byte.
module tb_vga_term_ctrl;

    localparam int ROWS = 30;
    localparam int COLS = 70;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_char = '0;
    logic [2:0] in_fg = '0;
    logic [2:0] in_bg = '0;
    logic       we;
    logic [4:0] wr_addr;
    logic [6:0] wc_addr;
    logic [7:0] w_ascii;
    logic [2:0] w_fg_color;
    logic [2:0] w_bg_color;
    logic [4:0] scroll_base;
    logic [4:0] cursor_row;
    logic [6:0] cursor_col;

    vga_term_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_char(in_char), .in_fg(in_fg), .in_bg(in_bg),
        .we(we), .wr_addr(wr_addr), .wc_addr(wc_addr),
        .w_ascii(w_ascii), .w_fg_color(w_fg_color), .w_bg_color(w_bg_color),
        .scroll_base(scroll_base), .cursor_row(cursor_row), .cursor_col(cursor_col)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Expected writes packed as {row, col, ascii, fg, bg}
    logic [25:0] exp_q[$];

    // Terminal model state
    int m_row = 0, m_col = 0, m_base = 0;

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [25:0] pack_wr(int r, int c, logic [7:0] ch, logic [2:0] fg, logic [2:0] bg);
        return {5'(r), 7'(c), ch, fg, bg};
    endfunction

    // Line feed in the model; returns the number of busy cycles it causes
    function automatic int model_lf(logic [2:0] fg, logic [2:0] bg);
        if (m_row < ROWS - 1) begin
            m_row++;
            return 0;
        end
        for (int c = 0; c < COLS; c++) exp_q.push_back(pack_wr(m_base, c, 8'h20, fg, bg));
        m_base = (m_base + 1) % ROWS;
        return COLS;
    endfunction

    // Monitor: every DUT write must match the head of the expectation queue
    always @(negedge clk) begin
        if (rst_n && we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", int'({wr_addr, wc_addr, w_ascii, w_fg_color, w_bg_color}), -1);
            end else begin
                logic [25:0] e;
                e = exp_q.pop_front();
                check("cmem_write", int'({wr_addr, wc_addr, w_ascii, w_fg_color, w_bg_color}), int'(e));
            end
        end
    end

    // Drive one byte, update the model, check immediate effects; optionally wait for idle
    task automatic send(input logic [7:0] ch, input logic [2:0] fg, input logic [2:0] bg,
                        input bit wait_done);
        int exp_busy, busy, guard;
        bit exp_we;
        exp_busy = 0;
        exp_we   = 0;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            exp_q.push_back(pack_wr((m_base + m_row) % ROWS, m_col, ch, fg, bg));
            exp_we = 1;
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                exp_busy = model_lf(fg, bg);
            end
        end else if (ch == 8'h0A) begin
            exp_busy = model_lf(fg, bg);
        end else if (ch == 8'h0D) begin
            m_col = 0;
        end else if (ch == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (ch == 8'h0C) begin
            m_base = 0; m_row = 0; m_col = 0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    exp_q.push_back(pack_wr(r, c, 8'h20, fg, bg));
            exp_busy = ROWS * COLS;
        end

        in_char  = ch;
        in_fg    = fg;
        in_bg    = bg;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 5000) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_char  = $urandom_range(0, 255);

        check("we_after_accept", int'(we), int'(exp_we));
        check("scroll_base", int'(scroll_base), m_base);
        check("cursor_row", int'(cursor_row), m_row);
        check("cursor_col", int'(cursor_col), m_col);

        if (wait_done) begin
            busy = 0;
            while (!in_ready && busy < 5000) begin
                @(posedge clk); #1; busy++;
            end
            check("busy_cycles", busy, exp_busy);
        end
    endtask

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(32'h20, 32'h7E));
    endfunction

    initial begin
        logic [7:0] other_bytes [4];
        other_bytes = '{8'h00, 8'h07, 8'h7F, 8'hC3};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_we", int'(we), 0);
        check("rst_addr", int'({wr_addr, wc_addr}), 0);
        check("rst_data", int'({w_ascii, w_fg_color, w_bg_color}), 0);
        check("rst_base", int'(scroll_base), 0);
        check("rst_cursor", int'({cursor_row, cursor_col}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First character, then fill row 0 and wrap to row 1
        send(8'h41, 3'd7, 3'd1, 1);
        for (int i = 0; i < COLS - 1; i++) send(rand_print(), 3'($urandom), 3'($urandom), 1);

        // Walk down to the bottom row, move to column 5, then LF scrolls
        for (int i = 0; i < ROWS - 2; i++) send(8'h0A, 3'd0, 3'd0, 1);
        for (int i = 0; i < 5; i++) send(rand_print(), 3'($urandom), 3'($urandom), 1);
        send(8'h0A, 3'd2, 3'd5, 1);

        // Scroll until base = ROWS-1, then print into the bottom-right corner
        for (int i = 0; i < ROWS - 2; i++) send(8'h0A, 3'($urandom), 3'($urandom), 1);
        check("base_at_last", int'(scroll_base), ROWS - 1);
        send(8'h0D, 3'd0, 3'd0, 1);
        for (int i = 0; i < COLS - 1; i++) send(rand_print(), 3'($urandom), 3'($urandom), 1);
        send(8'h5A, 3'd3, 3'd6, 1);

        // Form feed with bg 4
        send(8'h0C, 3'd1, 3'd4, 1);

        // Non-writing controls: CR, BS at column 0, BEL
        send(8'h0D, 3'd0, 3'd0, 1);
        send(8'h08, 3'd0, 3'd0, 1);
        send(8'h07, 3'd0, 3'd0, 1);
        repeat (2) @(posedge clk);
        #1;
        check("ctrl_no_writes_pending", exp_q.size(), 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [7:0] ch;
            r = $urandom_range(0, 99);
            if (r < 68)      ch = rand_print();
            else if (r < 82) ch = 8'h0A;
            else if (r < 88) ch = 8'h0D;
            else if (r < 94) ch = 8'h08;
            else if (r < 98) ch = other_bytes[$urandom_range(0, 3)];
            else             ch = 8'h0C;
            send(ch, 3'($urandom), 3'($urandom), 1);
        end
        repeat (2) @(posedge clk);
        #1;
        check("random_queue_drained", exp_q.size(), 0);

        // Reset during a screen clear
        send(8'h0C, 3'd5, 3'd2, 0);
        repeat (100) @(posedge clk);
        #1;
        check("clear_in_progress", int'(we), 1);
        rst_n = 1'b0;
        #1;
        check("we_drops_on_reset", int'(we), 0);
        exp_q.delete();
        m_row = 0; m_col = 0; m_base = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("ready_after_reset", int'(in_ready), 1);
        check("addr_after_reset", int'({wr_addr, wc_addr}), 0);
        repeat (20) @(posedge clk);
        #1;
        send(8'h78, 3'd6, 3'd3, 1);
        repeat (2) @(posedge clk);
        #1;
        check("final_queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
